// File: rtl/usb3_wr_ctrl.sv
// FX3 slave-FIFO write controller: buffers source words and
// issues full bursts, or short packets closed with PKTEND on flush.
module usb3_wr_ctrl #(
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int FLAG_LAT   = 3
) (
  input  logic        wrclock,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        flush,
  input  logic        USB3_FLAGB,
  output logic [31:0] USB3_DQ,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic        USB3_SLCS_N,
  output logic [1:0]  USB3_A,
  output logic [3:0]  usb_wr_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;

  localparam logic [CW-1:0] BLEN  = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GLAST = GW'(FLAG_LAT - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WAIT  = 4'd1;
  localparam logic [3:0] S_BURST = 4'd2;
  localparam logic [3:0] S_PKT   = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic [3:0]    state;
  logic [3:0]    state_nx;
  logic [CW-1:0] burst_n;
  logic [CW-1:0] beat;
  logic          short_pkt;
  logic          flush_pend;
  logic [GW-1:0] gap;
  logic          push;
  logic          pop;
  logic          discard;

  assign data_ready   = count < DEPTH;
  assign push         = data_valid & data_ready;
  assign discard      = (count == '0) && (state == S_IDLE);
  assign USB3_A       = 2'b00;
  assign usb_wr_state = state;

  // pop is issued on the edge that drops SLWR_N, so DQ and strobe align
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE:
        if (count >= BLEN || (flush_pend && count != '0))
          state_nx = S_WAIT;
      S_WAIT:
        if (USB3_FLAGB) begin
          state_nx = S_BURST;
          pop      = 1'b1;
        end
      S_BURST:
        if (beat < burst_n) pop = 1'b1;
        else state_nx = short_pkt ? S_PKT : S_GAP;
      S_PKT:
        state_nx = S_GAP;
      S_GAP:
        if (gap == GLAST) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (push) mem[wp] <= data;
  end

  always_ff @(posedge wrclock or posedge rst) begin
    if (rst) begin
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      state         <= S_IDLE;
      burst_n       <= '0;
      beat          <= '0;
      short_pkt     <= 1'b0;
      flush_pend    <= 1'b0;
      gap           <= '0;
      USB3_DQ       <= '0;
      USB3_SLWR_N   <= 1'b1;
      USB3_PKTEND_N <= 1'b1;
      USB3_SLCS_N   <= 1'b1;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == S_IDLE) begin
        if (count >= BLEN) begin
          burst_n   <= BLEN;
          short_pkt <= 1'b0;
        end else begin
          burst_n   <= count;
          short_pkt <= 1'b1;
        end
      end
      beat <= pop ? beat + CW'(1) : '0;
      gap  <= (state == S_GAP) ? gap + GW'(1) : '0;
      // a new flush wins over the clear so late words still get committed
      if (flush && !discard)
        flush_pend <= 1'b1;
      else if (state_nx == S_PKT && state != S_PKT)
        flush_pend <= 1'b0;
      if (pop) USB3_DQ <= mem[rp];
      USB3_SLWR_N   <= ~pop;
      USB3_PKTEND_N <= ~(state_nx == S_PKT);
      USB3_SLCS_N   <= (state_nx == S_IDLE);
    end
  end

endmodule

// File: tb/tb_usb3_wr_ctrl.sv
// Directed bench for usb3_wr_ctrl with a word-order scoreboard
// checked on every SLWR_N-low cycle.
module tb_usb3_wr_ctrl;

  logic        wrclock = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        flush = 1'b0;
  logic        USB3_FLAGB = 1'b1;
  logic [31:0] USB3_DQ;
  logic        USB3_SLWR_N;
  logic        USB3_PKTEND_N;
  logic        USB3_SLCS_N;
  logic [1:0]  USB3_A;
  logic [3:0]  usb_wr_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] q [$];
  int run = 0;
  int last_run = 0;
  int gap_run = 0;
  int last_gap = 0;
  int pkt_cnt = 0;
  int slwr_total = 0;

  usb3_wr_ctrl dut (
    .wrclock       (wrclock),
    .rst           (rst),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .flush         (flush),
    .USB3_FLAGB    (USB3_FLAGB),
    .USB3_DQ       (USB3_DQ),
    .USB3_SLWR_N   (USB3_SLWR_N),
    .USB3_PKTEND_N (USB3_PKTEND_N),
    .USB3_SLCS_N   (USB3_SLCS_N),
    .USB3_A        (USB3_A),
    .usb_wr_state  (usb_wr_state)
  );

  always #5 wrclock = ~wrclock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wrclock);
    #1;
  endtask

  // scoreboard and strobe bookkeeping
  always @(negedge wrclock) begin
    if (rst) begin
      run     = 0;
      gap_run = 0;
    end else begin
      if (!USB3_SLWR_N) begin
        run++;
        slwr_total++;
        if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("dq_order", USB3_DQ, q.pop_front());
      end else if (run != 0) begin
        last_run = run;
        run      = 0;
      end
      if (!USB3_PKTEND_N) begin
        pkt_cnt++;
        chk("pktend_slwr_hi", 32'(USB3_SLWR_N), 32'd1);
      end
      if (usb_wr_state == 4'd4) gap_run++;
      else if (gap_run != 0) begin
        last_gap = gap_run;
        gap_run  = 0;
      end
    end
  end

  task automatic push_words(input int n, input logic [31:0] base);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!data_ready && t < 5000) begin
        data_valid = 1'b0;
        tick();
        t++;
      end
      if (!data_ready) begin
        chk("push_tmo", 32'd1, 32'd0);
        break;
      end
      data       = base + 32'(i);
      data_valid = 1'b1;
      q.push_back(base + 32'(i));
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_burst_done(input string tag);
    int t = 0;
    while (usb_wr_state == 4'd0 && t < 2000) begin tick(); t++; end
    while (usb_wr_state != 4'd0 && t < 4000) begin tick(); t++; end
    chk({tag, "_tmo"}, 32'(t < 4000), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_slwr"}, 32'(USB3_SLWR_N), 32'd1);
    chk({tag, "_pktend"}, 32'(USB3_PKTEND_N), 32'd1);
    chk({tag, "_slcs"}, 32'(USB3_SLCS_N), 32'd1);
    chk({tag, "_dq"}, USB3_DQ, 32'd0);
    chk({tag, "_a"}, 32'(USB3_A), 32'd0);
    chk({tag, "_state"}, 32'(usb_wr_state), 32'd0);
    chk({tag, "_ready"}, 32'(data_ready), 32'd1);
  endtask

  initial begin
    int p0;
    int s0;
    int bad;
    int t;
    logic [31:0] c1;
    logic [31:0] c2;

    // reset state
    tick();
    tick();
    chk_reset_outs("rst");
    rst = 1'b0;

    // one full burst
    USB3_FLAGB = 1'b1;
    p0 = pkt_cnt;
    push_words(256, 32'd0);
    wait_burst_done("full");
    chk("full_len", 32'(last_run), 32'd256);
    chk("full_nopkt", 32'(pkt_cnt - p0), 32'd0);
    chk("full_gap", 32'(last_gap), 32'd3);

    // short packet via flush
    p0 = pkt_cnt;
    push_words(10, 32'h100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_burst_done("short");
    chk("short_len", 32'(last_run), 32'd10);
    chk("short_pkt", 32'(pkt_cnt - p0), 32'd1);
    chk("short_gap", 32'(last_gap), 32'd3);
    chk("short_pend", 32'(dut.flush_pend), 32'd0);
    chk("short_q", 32'(q.size()), 32'd0);

    // flag held low, then a burst that survives a mid-burst flag drop
    USB3_FLAGB = 1'b0;
    push_words(300, 32'h200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (usb_wr_state !== 4'd1 || USB3_SLWR_N !== 1'b1) bad++;
      tick();
    end
    chk("flag_hold", 32'(bad), 32'd0);
    USB3_FLAGB = 1'b1;
    t = 0;
    while (USB3_SLWR_N && t < 100) begin tick(); t++; end
    repeat (50) tick();
    USB3_FLAGB = 1'b0;
    wait_burst_done("flag");
    chk("flag_len", 32'(last_run), 32'd256);
    chk("flag_cnt", 32'(dut.count), 32'd44);

    // streaming during a burst, then fill to full across the wrap
    push_words(256, 32'h1000);
    chk("stream_wait", 32'(usb_wr_state), 32'd1);
    c1 = '0;
    c2 = '1;
    fork
      begin
        USB3_FLAGB = 1'b1;
        push_words(100, 32'h2000);
      end
      begin
        int tb = 0;
        while (USB3_SLWR_N && tb < 50) begin tick(); tb++; end
        repeat (5) tick();
        c1 = 32'(dut.count);
        repeat (40) tick();
        c2 = 32'(dut.count);
      end
    join
    chk("stream_steady", c2, c1);
    wait_burst_done("stream");
    chk("stream_len", 32'(last_run), 32'd256);
    USB3_FLAGB = 1'b0;
    push_words(368, 32'h3000);
    chk("full_ready", 32'(data_ready), 32'd0);
    chk("full_cnt", 32'(dut.count), 32'd512);
    data       = 32'hdeadbeef;
    data_valid = 1'b1;
    repeat (4) tick();
    data_valid = 1'b0;
    chk("no_ovf", 32'(dut.count), 32'd512);
    USB3_FLAGB = 1'b1;
    t = 0;
    while (!(dut.count == '0 && usb_wr_state == 4'd0) && t < 3000) begin
      tick();
      t++;
    end
    chk("drain_tmo", 32'(t < 3000), 32'd1);
    chk("drain_q", 32'(q.size()), 32'd0);

    // reset at burst word 100
    push_words(256, 32'h4000);
    t = 0;
    while (USB3_SLWR_N && t < 100) begin tick(); t++; end
    repeat (99) tick();
    chk("mid_slwr", 32'(USB3_SLWR_N), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outs("async");
    q.delete();
    repeat (3) tick();
    chk("rst_cnt", 32'(dut.count), 32'd0);
    rst = 1'b0;
    push_words(256, 32'h5000);
    wait_burst_done("post");
    chk("post_len", 32'(last_run), 32'd256);
    chk("post_q", 32'(q.size()), 32'd0);

    // flush with nothing buffered
    s0 = slwr_total;
    p0 = pkt_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (usb_wr_state !== 4'd0) bad++;
      tick();
    end
    chk("empty_idle", 32'(bad), 32'd0);
    chk("empty_slwr", 32'(slwr_total - s0), 32'd0);
    chk("empty_pkt", 32'(pkt_cnt - p0), 32'd0);
    chk("empty_pend", 32'(dut.flush_pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb3_wr_ctrl.md
USB3_WR_CTRL -- requirements
Module: usb3_wr_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 256: words per full FX3 write burst.
REQ-002 Parameter FIFO_DEPTH, default 512: internal buffer depth in 32-bit words, a power of two and at least 2*BURST_LEN.
REQ-003 Parameter FLAG_LAT, default 3: idle cycles after each burst so the FX3 flag can settle.
REQ-004 wrclock  in  1  single clock for all logic (FX3 PCLK domain).
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 data  in  32  source word.
REQ-007 data_valid  in  1  source word present.
REQ-008 data_ready  out  1  block can accept a word.
REQ-009 flush  in  1  one-cycle request to commit buffered words as a short packet.
REQ-010 USB3_FLAGB  in  1  FX3 partial flag: 1 = at least BURST_LEN words free; 0 = nearly full.
REQ-011 USB3_DQ  out  32  FX3 data bus, driven by this block.
REQ-012 USB3_SLWR_N  out  1  FX3 write strobe, active-low.
REQ-013 USB3_PKTEND_N  out  1  FX3 packet-end strobe, active-low.
REQ-014 USB3_SLCS_N  out  1  FX3 chip select, active-low.
REQ-015 USB3_A  out  2  FX3 socket address, constant 2'b00.
REQ-016 usb_wr_state  out  4  current state encoding, for debug.

Function
REQ-017 The buffer SHALL be a FWFT FIFO of FIFO_DEPTH words with a count of log2(FIFO_DEPTH)+1 bits.
- push = data_valid & data_ready; pop = one word per cycle while SLWR_N is low.
- Push and pop in the same cycle SHALL leave the count unchanged.
- Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 data_ready SHALL equal (count < FIFO_DEPTH), combinationally from registered count; a push while full SHALL be impossible.
REQ-019 flush SHALL set a sticky flush_pend bit.
- flush_pend SHALL clear on entry to PKTEND.
- A flush arriving while count==0 and no burst is pending SHALL be discarded.
REQ-020 State machine encodings: IDLE=0, WAIT_FLAG=1, BURST=2, PKTEND=3, GAP=4.
REQ-021 IDLE: if count>=BURST_LEN, latch burst_n=BURST_LEN, short=0, and go to WAIT_FLAG.
- Else if flush_pend and count>0, latch burst_n=count, short=1, and go to WAIT_FLAG.
- Else stay in IDLE.
REQ-022 WAIT_FLAG: go to BURST on USB3_FLAGB==1; otherwise stay, with SLWR_N held high.
REQ-023 BURST: SLWR_N SHALL be low with USB3_DQ equal to the FIFO head, popping one word per cycle for exactly burst_n consecutive cycles.
- Then go to PKTEND if short==1, else to GAP.
- USB3_FLAGB falling mid-burst SHALL NOT truncate the burst.
REQ-024 PKTEND: PKTEND_N SHALL be low for exactly one cycle with SLWR_N high, then go to GAP.
REQ-025 GAP: SLWR_N and PKTEND_N SHALL stay high for FLAG_LAT cycles, then go to IDLE.
REQ-026 USB3_SLCS_N SHALL be low in every state except IDLE.
REQ-027 All FX3 outputs SHALL be registered. USB3_DQ SHALL hold its last value whenever SLWR_N is high.
REQ-028 Words SHALL leave in exactly the order accepted; no word lost or duplicated.

Reset
REQ-029 While rst=1, the following SHALL hold, including when rst asserts mid-BURST (the partial burst is abandoned):
- state=IDLE, FIFO empty, flush_pend=0, burst counter=0;
- USB3_SLWR_N=1, USB3_PKTEND_N=1, USB3_SLCS_N=1, USB3_DQ=0, USB3_A=0, usb_wr_state=0;
- data_ready=1.
REQ-030 The first push SHALL be accepted on the first rising wrclock edge after rst deasserts.

Verification
REQ-031 Push 256 words 0..255 with FLAGB=1 -> SLWR_N low for 256 consecutive cycles, DQ=0..255 in order, PKTEND_N never low, then 3 GAP cycles.
REQ-032 Push 10 words, then pulse flush -> 10-cycle SLWR_N burst, then one PKTEND_N low cycle, then GAP; flush_pend=0 afterwards.
REQ-033 Hold FLAGB=0 with 300 words buffered -> state stays 1 and SLWR_N stays high; raise FLAGB -> 256-word burst, leaving count=44.
REQ-034 Push continuously at 1 word/cycle during a burst -> count holds steady; fill to 512 -> data_ready=0; no overflow and ordering preserved across the pointer wrap.
REQ-035 Assert rst at burst word 100 -> outputs reach reset values asynchronously; after release FIFO is empty and the next 256 pushes produce a clean burst starting at the first new word.
REQ-036 Pulse flush with an empty FIFO -> no SLWR_N or PKTEND_N activity, and state stays IDLE.
